muldiv_unit: RTL

- Iterative multiply/divide unit downstream of the register file: consumes the two read-port operands (Data1/Data2) and produces a 64-bit HI/LO result for later write-back through the register-file write port.
- Used for MIPS-style MULT/MULTU/DIV/DIVU, which are too slow for the single-cycle ALU path.
- Runs one shift-add (multiply) or restoring-subtract (divide) step per clock, under a start/busy/done handshake that the control unit uses to stall.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and small decode helpers.
package muldiv_pkg;

    // Operation encodings as presented on the op input
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for the two's-complement operations (MULT, DIV)
    function automatic logic op_is_signed(input logic [1:0] op_f);
        return (op_f == OP_MULT) || (op_f == OP_DIV);
    endfunction

    // True for the divide operations (DIV, DIVU)
    function automatic logic op_is_div(input logic [1:0] op_f);
        return (op_f == OP_DIV) || (op_f == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit. One shift-add (multiply) or
// restoring-subtract (divide) step per clock on magnitudes, with the sign
// applied to the 2*WIDTH result when it is registered into hi/lo.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Shared accumulator: multiply holds {partial product, remaining multiplier},
    // divide holds {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [CNT_W-1:0]   r_cnt;
    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_signed;
    logic               w_div0;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_cand;
    logic [WIDTH+1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_fixed;
    logic               w_last;

    // Apply result signs: MULT negates the whole product, DIV negates the
    // quotient on differing signs and gives the remainder the dividend's sign.
    function automatic logic [2*WIDTH-1:0] fix_result(
        input logic [1:0]         op_f,
        input logic [2*WIDTH-1:0] raw,
        input logic               sa,
        input logic               sb
    );
        logic [2*WIDTH-1:0] res;
        logic [WIDTH-1:0]   q;
        logic [WIDTH-1:0]   r;
        res = raw;
        q   = raw[WIDTH-1:0];
        r   = raw[2*WIDTH-1:WIDTH];
        if (op_is_div(op_f)) begin
            if (sa ^ sb) begin
                q = -q;
            end
            if (sa) begin
                r = -r;
            end
            res = {r, q};
        end else if (sa ^ sb) begin
            res = -raw;
        end
        return res;
    endfunction

    // Operand capture: magnitudes and sign flags for the accepted operation.
    // Divide by zero is run as unsigned so hi returns A untouched.
    always_comb begin
        w_accept = start && ((r_state == IDLE) || (r_state == DONE));
        w_signed = op_is_signed(op);
        w_div0   = op_is_div(op) && (B == '0);
        w_sa     = w_signed && !w_div0 && A[WIDTH-1];
        w_sb     = w_signed && !w_div0 && B[WIDTH-1];
        w_mag_a  = w_sa ? -A : A;
        w_mag_b  = w_sb ? -B : B;
    end

    // One datapath step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : '0)};
        w_div_cand = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff = {1'b0, w_div_cand} - {2'b00, r_b};
        if (op_is_div(r_op)) begin
            if (!w_div_diff[WIDTH+1]) begin
                w_acc_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_next = {w_div_cand[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
        w_fixed = fix_result(r_op, w_acc_next, r_sign_a, r_sign_b);
        w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    end

    // Sequencer, iteration counter, operand registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= OP_MULT;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            // Accept from IDLE or back-to-back from DONE
            r_state  <= RUN;
            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
            r_b      <= w_mag_b;
            r_op     <= op;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_fixed[2*WIDTH-1:WIDTH];
                        r_lo    <= w_fixed[WIDTH-1:0];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
